// File: rtl/mips_pkg.sv
// Shared defaults for the instruction fetch front end.
// Widths, reset vector, sequential step and queue sizing.
package mips_pkg;

    localparam int          DEF_ADDR_WIDTH  = 32;
    localparam int          DEF_INSTR_WIDTH = 32;
    localparam int          DEF_QUEUE_DEPTH = 4;
    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STEP     = 32'h0000_0004;

    // Bits needed to hold a count of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries for the prefetch unit.
// Flush empties it in one cycle; the head reads as zero when empty.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = DEF_QUEUE_DEPTH,
    parameter int WIDTH = DEF_ADDR_WIDTH + DEF_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Handshake qualification and pointer/count next state.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so stale data never leaks out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        empty_o     = (count_q == '0);
        count_o     = count_q;
        head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: credit-limited sequential fetch into a
// small queue, with redirect flush and stale-response dropping.
module instruction_prefetch_unit
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int                    QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEF_RESET_PC),
    parameter logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(DEF_PC_STEP)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [ADDR_WIDTH-1:0]        imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0]       imem_resp_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_WIDTH-1:0]        out_pc,
    output logic [INSTR_WIDTH-1:0]       out_instr,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy
);

    localparam int CW = count_width(QUEUE_DEPTH);
    localparam int DW = count_width(2 * QUEUE_DEPTH);
    localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q;
    logic [ADDR_WIDTH-1:0] resp_pc_d;
    logic [CW-1:0]         live_q;
    logic [CW-1:0]         live_d;
    logic [DW-1:0]         drop_q;
    logic [DW-1:0]         drop_d;

    logic [CW:0]           credit_used;
    logic                  req_fire;
    logic                  resp_drop;
    logic                  resp_live;
    logic                  q_push;
    logic                  q_pop;
    logic                  q_empty;
    logic [EW-1:0]         q_head;
    logic [CW-1:0]         q_count;

    // Request credit: in-flight live requests plus queued entries
    // never exceed the queue depth, so every live response fits.
    always_comb begin
        credit_used    = {1'b0, live_q} + {1'b0, q_count};
        imem_req_valid = !redirect_valid
                      && (credit_used < (CW + 1)'(QUEUE_DEPTH));
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
    end

    // Response classification: outstanding stale responses drain
    // first, then live ones; anything else is spurious and ignored.
    always_comb begin
        resp_drop = 1'b0;
        resp_live = 1'b0;
        if (imem_resp_valid) begin
            if (drop_q != '0) begin
                resp_drop = 1'b1;
            end else if (live_q != '0) begin
                resp_live = 1'b1;
            end
        end
        q_push = resp_live && !redirect_valid;
        q_pop  = out_valid && out_ready;
    end

    // PC and counter next state; a redirect moves every live
    // request (minus one answered this cycle) into the drop count.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            live_d     = '0;
            drop_d     = drop_q + DW'(live_q)
                       - DW'(resp_drop || resp_live);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (resp_live) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end
            unique case ({req_fire, resp_live})
                2'b10:   live_d = live_q + 1'b1;
                2'b01:   live_d = live_q - 1'b1;
                default: live_d = live_q;
            endcase
            if (resp_drop) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (q_push),
        .push_data_i ({resp_pc_q, imem_resp_data}),
        .pop_i       (q_pop),
        .head_data_o (q_head),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    // Decode-side view of the queue head.
    always_comb begin
        out_valid = !q_empty;
        out_pc    = q_head[EW-1:INSTR_WIDTH];
        out_instr = q_head[INSTR_WIDTH-1:0];
        occupancy = q_count;
    end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Self-checking bench for instruction_prefetch_unit: directed
// scenarios plus randomized traffic against an epoch-based model.
module tb_instruction_prefetch_unit;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    instruction_prefetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .occupancy       (occupancy)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [2:0]  occ;
        logic        rv;
        logic [31:0] ra;
    } snap_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    mreq_t       memq[$];
    ent_t        mq[$];
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] fpc = '0;
    snap_t       obs;
    snap_t       expd;
    logic [31:0] obs_addr;
    bit          obs_fire;
    int          errs = 0;
    int          checks = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // One clock: drive inputs, predict, sample at negedge, advance model.
    task automatic run_cycle(input bit rst, input bit redir,
                             input logic [31:0] rpc, input bit rq_rdy,
                             input bit o_rdy, input bit spur);
        int    live;
        int    due;
        bit    mresp;
        bit    erv;
        bit    epop;
        mreq_t h;
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rq_rdy;
        out_ready      = o_rdy;
        mresp = !rst && memq.size() != 0 && memq[0].due <= cyc;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mresp) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memfn(memq[0].addr);
        end else if (spur && !rst && memq.size() == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = $urandom;
        end
        live = 0;
        foreach (memq[i]) if (memq[i].epoch == epoch) live++;
        erv       = !redir && (live + mq.size() < D);
        expd.v    = mq.size() != 0;
        expd.pc   = expd.v ? mq[0].pc : 32'h0;
        expd.ins  = expd.v ? mq[0].ins : 32'h0;
        expd.occ  = 3'(mq.size());
        expd.rv   = erv;
        expd.ra   = erv ? fpc : 32'h0;
        epop      = expd.v && o_rdy;
        @(negedge clk);
        obs = {out_valid, out_pc, out_instr, occupancy, imem_req_valid,
               (erv ? imem_req_addr : 32'h0)};
        obs_addr = imem_req_addr;
        obs_fire = imem_req_valid && rq_rdy;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            memq.delete();
            epoch++;
            fpc      = '0;
            last_due = -1;
        end else begin
            if (epop) void'(mq.pop_front());
            if (mresp) begin
                h = memq.pop_front();
                if (!redir && h.epoch == epoch)
                    mq.push_back('{h.addr, memfn(h.addr)});
            end
            if (redir) begin
                mq.delete();
                epoch++;
                fpc = rpc;
            end else if (erv && rq_rdy) begin
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                memq.push_back('{fpc, epoch, due});
                last_due = due;
                fpc = fpc + 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        run_cycle(1, 1, 32'h40, 1, 1, 0);
        run_cycle(1, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== expd) begin
            errs++;
            $display("FAIL reset_model got=%h want=%h", obs, expd);
        end
        checks++;
        if ({obs.v, obs.pc, obs.ins, obs.occ} !== '0) begin
            errs++;
            $display("FAIL reset_outputs got v=%b pc=%h ins=%h occ=%0d want all zero",
                     obs.v, obs.pc, obs.ins, obs.occ);
        end
        checks++;
        if (obs.rv !== 1'b1 || obs_addr !== 32'h0) begin
            errs++;
            $display("FAIL reset_req got valid=%b addr=%h want valid=1 addr=0",
                     obs.rv, obs_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        lat_min = 1;
        lat_max = 1;
        run_cycle(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 14; c++) begin
            run_cycle(0, 0, 0, 1, 1, 0);
            checks++;
            if (obs !== expd) begin
                errs++;
                $display("FAIL stream_model c=%0d got=%h want=%h", c, obs, expd);
            end
            if (c >= 2) begin
                want = 32'(4 * (c - 2));
                checks++;
                if (obs.v !== 1'b1 || obs.pc !== want || obs.ins !== memfn(want)) begin
                    errs++;
                    $display("FAIL stream_seq c=%0d got v=%b pc=%h ins=%h want pc=%h ins=%h",
                             c, obs.v, obs.pc, obs.ins, want, memfn(want));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          fires;
        logic [31:0] popped[$];
        logic [31:0] first_addr;
        bit          seen;
        lat_min = 1;
        lat_max = 1;
        fires   = 0;
        run_cycle(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            run_cycle(0, 0, 0, 1, 0, 0);
            fires += int'(obs_fire);
            checks++;
            if (obs !== expd) begin
                errs++;
                $display("FAIL bp_model c=%0d got=%h want=%h", c, obs, expd);
            end
        end
        checks++;
        if (fires != 4 || obs.occ !== 3'd4 || obs.rv !== 1'b0) begin
            errs++;
            $display("FAIL bp_saturate got fires=%0d occ=%0d req_valid=%b want 4 4 0",
                     fires, obs.occ, obs.rv);
        end
        seen       = 1'b0;
        first_addr = '0;
        for (int c = 0; c < 8; c++) begin
            run_cycle(0, 0, 0, 1, 1, 0);
            if (obs.v) popped.push_back(obs.pc);
            if (obs_fire && !seen) begin
                seen       = 1'b1;
                first_addr = obs_addr;
            end
            checks++;
            if (obs !== expd) begin
                errs++;
                $display("FAIL bp_release_model c=%0d got=%h want=%h", c, obs, expd);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (popped.size() <= i || popped[i] !== 32'(4 * i)) begin
                errs++;
                $display("FAIL bp_order i=%0d got=%h want=%h", i,
                         (popped.size() > i) ? popped[i] : 32'hx, 32'(4 * i));
            end
        end
        checks++;
        if (!seen || first_addr !== 32'h10) begin
            errs++;
            $display("FAIL bp_resume got seen=%b addr=%h want addr=00000010",
                     seen, first_addr);
        end
    endtask

    // Runs until the first valid output; reports its pc via 'pc'.
    task automatic test_redirect_inflight();
        bit          found;
        logic [31:0] pc;
        lat_min = 3;
        lat_max = 3;
        run_cycle(1, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 1, 0);
        run_cycle(0, 0, 0, 1, 1, 0);
        run_cycle(0, 1, 32'h100, 1, 1, 0);
        found = 1'b0;
        pc    = '0;
        for (int c = 0; c < 20 && !found; c++) begin
            run_cycle(0, 0, 0, 1, 1, 0);
            checks++;
            if (obs !== expd) begin
                errs++;
                $display("FAIL redir_model c=%0d got=%h want=%h", c, obs, expd);
            end
            if (obs.v) begin
                found = 1'b1;
                pc    = obs.pc;
            end
        end
        checks++;
        if (!found || pc !== 32'h100) begin
            errs++;
            $display("FAIL redir_first got found=%b pc=%h want pc=00000100", found, pc);
        end
    endtask

    task automatic test_redirect_pop_resp();
        bit          found;
        logic [31:0] pc;
        lat_min = 1;
        lat_max = 1;
        run_cycle(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) run_cycle(0, 0, 0, 1, 1, 0);
        run_cycle(0, 1, 32'h400, 1, 1, 0);
        checks++;
        if (obs !== expd || obs.v !== 1'b1) begin
            errs++;
            $display("FAIL rpr_cycle got=%h want=%h", obs, expd);
        end
        run_cycle(0, 0, 0, 1, 1, 0);
        checks++;
        if (obs.v !== 1'b0 || obs.occ !== 3'd0) begin
            errs++;
            $display("FAIL rpr_empty got v=%b occ=%0d want 0 0", obs.v, obs.occ);
        end
        found = 1'b0;
        pc    = '0;
        for (int c = 0; c < 10 && !found; c++) begin
            run_cycle(0, 0, 0, 1, 1, 0);
            if (obs.v) begin
                found = 1'b1;
                pc    = obs.pc;
            end
        end
        checks++;
        if (!found || pc !== 32'h400) begin
            errs++;
            $display("FAIL rpr_next got found=%b pc=%h want pc=00000400", found, pc);
        end
    endtask

    task automatic test_back_to_back();
        bit          found;
        logic [31:0] pc;
        int          bad;
        lat_min = 2;
        lat_max = 2;
        run_cycle(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) run_cycle(0, 0, 0, 1, 1, 0);
        run_cycle(0, 1, 32'h200, 1, 1, 0);
        run_cycle(0, 1, 32'h300, 1, 1, 0);
        found = 1'b0;
        pc    = '0;
        bad   = 0;
        for (int c = 0; c < 12; c++) begin
            run_cycle(0, 0, 0, 1, 1, 0);
            checks++;
            if (obs !== expd) begin
                errs++;
                $display("FAIL b2b_model c=%0d got=%h want=%h", c, obs, expd);
            end
            if (obs.v && !found) begin
                found = 1'b1;
                pc    = obs.pc;
            end
            if (obs.v && obs.pc[31:8] == 24'h2) bad++;
        end
        checks++;
        if (!found || pc !== 32'h300 || bad != 0) begin
            errs++;
            $display("FAIL b2b_first got pc=%h stale200=%0d want pc=00000300 stale200=0",
                     pc, bad);
        end
    endtask

    task automatic test_reset_midflight();
        bit reached;
        lat_min = 3;
        lat_max = 3;
        run_cycle(1, 0, 0, 0, 0, 0);
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            run_cycle(0, 0, 0, 1, 0, 0);
            checks++;
            if (obs !== expd) begin
                errs++;
                $display("FAIL rstmid_model c=%0d got=%h want=%h", c, obs, expd);
            end
            if (obs.occ == 3'd2) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errs++;
            $display("FAIL rstmid_fill got occ=%0d want 2", obs.occ);
        end
        run_cycle(1, 1, 32'h500, 1, 1, 0);
        run_cycle(0, 0, 0, 0, 1, 0);
        checks++;
        if (obs.occ !== 3'd0 || obs.v !== 1'b0 || obs.rv !== 1'b1 || obs_addr !== 32'h0) begin
            errs++;
            $display("FAIL rstmid_state got occ=%0d v=%b rv=%b addr=%h want 0 0 1 00000000",
                     obs.occ, obs.v, obs.rv, obs_addr);
        end
        for (int c = 0; c < 12; c++) begin
            run_cycle(0, 0, 0, 1, 1, 0);
            checks++;
            if (obs !== expd) begin
                errs++;
                $display("FAIL rstmid_after c=%0d got=%h want=%h", c, obs, expd);
            end
        end
    endtask

    task automatic test_random();
        bit          rst;
        bit          redir;
        logic [31:0] rpc;
        lat_min = 1;
        lat_max = 4;
        run_cycle(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom % 200) == 0;
            redir = ($urandom % 16) == 0;
            rpc   = {16'h0, 14'($urandom), 2'b00};
            run_cycle(rst, redir, rpc, ($urandom % 4) != 0,
                      ($urandom % 3) != 0, ($urandom % 8) == 0);
            if (!rst) begin
                checks++;
                if (obs !== expd) begin
                    errs++;
                    $display("FAIL random_model c=%0d got=%h want=%h", c, obs, expd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_pop_resp();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
